// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops are rotates, shifts, ADD, XOR, AND/ANDN and both SUB directions.
// Their result is captured at the accepting edge, so there is one result every 2 cycles.
// MUL is an optional shift-add multiplier. It takes one multiplier bit per cycle for WIDTH cycles.
// Results and flags are registered and are held in DONE until out_ready is seen.
//
// Configuration macro: ALU_SEQ_MUL_EN builds the MUL state and the multiplier datapath.
// When the macro is undefined, op 1001 is treated as illegal.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   request handshake (in_ready high only in IDLE)
//   A, B                 operands; B[SHW-1:0] is the shift/rotate count
//   op                   operation code
//   invB                 AND uses ~B
//   sign                 ADD/SUB ofl reports signed overflow instead of carry
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   out, ofl, z, co, err registered result, overflow, zero, carry, illegal op
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ofl,
    output logic             z,
    output logic             co,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpRol   = 4'b0000;
    localparam logic [3:0] OpSll   = 4'b0001;
    localparam logic [3:0] OpRor   = 4'b0010;
    localparam logic [3:0] OpSrl   = 4'b0011;
    localparam logic [3:0] OpAdd   = 4'b0100;
    localparam logic [3:0] OpXor   = 4'b0101;
    localparam logic [3:0] OpAnd   = 4'b0110;
    localparam logic [3:0] OpSubAb = 4'b0111;
    localparam logic [3:0] OpSubBa = 4'b1000;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OpMul   = 4'b1001;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StDone} state_e;
`endif

    state_e state_q, state_d;

    logic [WIDTH-1:0] out_q, out_d;
    logic             ofl_q, ofl_d, z_q, z_d, co_q, co_d, err_q, err_d;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [WIDTH-1:0]   add_a, add_b;
    logic               add_cin;
    logic [WIDTH:0]     add_sum;
    logic               add_sovf;
    logic [WIDTH-1:0]   res;
    logic               res_ofl, res_co, res_err;
    logic               load_result;

    assign shamt = B[SHW-1:0];
    // Rotates come from shifting the operand concatenated with itself.
    assign rot_l = {A, A} << shamt;
    assign rot_r = {A, A} >> shamt;

    // One shared adder: a SUB is minuend + ~subtrahend + 1.
    always_comb begin
        add_a   = A;
        add_b   = B;
        add_cin = 1'b0;
        if (op == OpSubAb) begin
            add_b   = ~B;
            add_cin = 1'b1;
        end else if (op == OpSubBa) begin
            add_a   = B;
            add_b   = ~A;
            add_cin = 1'b1;
        end
    end

    assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_sovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != add_a[WIDTH-1]);

    always_comb begin
        res     = '0;
        res_ofl = 1'b0;
        res_co  = 1'b0;
        res_err = 1'b0;
        case (op)
            OpRol: res = rot_l[2*WIDTH-1:WIDTH];
            OpSll: res = A << shamt;
            OpRor: res = rot_r[WIDTH-1:0];
            OpSrl: res = A >> shamt;
            OpXor: res = A ^ B;
            OpAnd: res = invB ? (A & ~B) : (A & B);
            OpAdd, OpSubAb, OpSubBa: begin
                res     = add_sum[WIDTH-1:0];
                res_co  = add_sum[WIDTH];
                res_ofl = sign ? add_sovf : add_sum[WIDTH];
            end
            default: res_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // ---------------- shift-add multiplier ----------------
    // The upper half of prod accumulates the product.
    // The lower half starts as the multiplier and is shifted out one bit per cycle.
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum;

    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                       (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
`endif

    // ---------------- control ----------------
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        ofl_d       = ofl_q;
        z_d         = z_q;
        co_d        = co_q;
        err_d       = err_q;
        load_result = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OpMul) begin
                        state_d = StMul;
                        mcand_d = A;
                        prod_d  = {{WIDTH{1'b0}}, B};
                        cnt_d   = '0;
                    end else begin
                        load_result = 1'b1;
                    end
`else
                    load_result = 1'b1;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            StMul: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = StDone;
                    out_d   = prod_step[WIDTH-1:0];
                    ofl_d   = |prod_step[2*WIDTH-1:WIDTH];
                    co_d    = |prod_step[2*WIDTH-1:WIDTH];
                    z_d     = (prod_step[WIDTH-1:0] == '0);
                    err_d   = 1'b0;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load_result) begin
            state_d = StDone;
            out_d   = res;
            ofl_d   = res_ofl;
            co_d    = res_co;
            err_d   = res_err;
            z_d     = (res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            out_q   <= '0;
            ofl_q   <= 1'b0;
            z_q     <= 1'b1;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ofl_q   <= ofl_d;
            z_q     <= z_d;
            co_q    <= co_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = out_q;
    assign ofl       = ofl_q;
    assign z         = z_q;
    assign co        = co_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Flags are compared as the packed vector {ofl, z, co, err}.
module tb_alu_seq;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b;
    logic [3:0]       op;
    logic             invb, sgn;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out;
    logic             ofl, z, co, err;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .op        (op),
        .invB      (invb),
        .sign      (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ofl       (ofl),
        .z         (z),
        .co        (co),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency to out_valid, check the result, then release it.
    task automatic run(input string tag, input logic [3:0] o, input logic [15:0] va,
                       input logic [15:0] vb, input logic iv, input logic sg,
                       input logic [15:0] e_out, input logic [3:0] e_flags, input int e_lat);
        int lat;
        check({tag, ".rdy"}, {63'd0, in_ready}, 64'd1);
        op = o; a = va; b = vb; invb = iv; sgn = sg; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        check({tag, ".lat"}, 64'(lat), 64'(e_lat));
        check({tag, ".out"}, 64'(out), 64'(e_out));
        check({tag, ".flags"}, 64'({ofl, z, co, err}), 64'(e_flags));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle"}, 64'({out_valid, in_ready}), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; invb = 1'b0; sgn = 1'b0;
        #12;
        check("rst.ctl", 64'({out_valid, in_ready}), 64'd1);
        check("rst.out", 64'(out), 64'd0);
        check("rst.flags", 64'({ofl, z, co, err}), 64'b0100);
        @(negedge clk);
        rst_n = 1'b1;

        run("add_sovf", 4'b0100, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 4'b1000, 1);
        run("add_carry", 4'b0100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1110, 1);
        run("sub_ab_eq", 4'b0111, 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 4'b0110, 1);
        run("sub_ab_ovf", 4'b0111, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b1010, 1);
        run("sub_ba", 4'b1000, 16'h0003, 16'h0001, 1'b0, 1'b0, 16'hFFFE, 4'b0000, 1);
        run("ror", 4'b0010, 16'h8001, 16'h0011, 1'b0, 1'b0, 16'hC000, 4'b0000, 1);
        run("sll", 4'b0001, 16'h0001, 16'h000F, 1'b0, 1'b0, 16'h8000, 4'b0000, 1);
        run("rol", 4'b0000, 16'h8001, 16'h0004, 1'b0, 1'b0, 16'h0018, 4'b0000, 1);
        run("rol_cnt0", 4'b0000, 16'h1234, 16'h0010, 1'b0, 1'b0, 16'h1234, 4'b0000, 1);
        run("srl", 4'b0011, 16'h8000, 16'h00F3, 1'b0, 1'b0, 16'h1000, 4'b0000, 1);
        run("xor", 4'b0101, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 4'b0100, 1);
        run("and", 4'b0110, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000, 4'b0000, 1);
        run("andn", 4'b0110, 16'hF0F0, 16'hFF00, 1'b1, 1'b0, 16'h00F0, 4'b0000, 1);
        run("illegal_f", 4'b1111, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 4'b0101, 1);
        run("illegal_a", 4'b1010, 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b0101, 1);
`ifdef ALU_SEQ_MUL_EN
        run("mul_ovf", 4'b1001, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 4'b1110, 17);
        run("mul_small", 4'b1001, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h000F, 4'b0000, 17);
        run("mul_big", 4'b1001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0001, 4'b1010, 17);
`else
        run("mul_off", 4'b1001, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 4'b0101, 1);
`endif

        // Hold in DONE with out_ready low while a competing request is offered.
        op = 4'b0100; a = 16'h0002; b = 16'h0003; sgn = 1'b0; invb = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        op = 4'b0101; a = 16'hFFFF; b = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            check("hold.out", 64'(out), 64'h5);
            check("hold.ctl", 64'({out_valid, in_ready}), 64'b10);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold.idle", 64'({out_valid, in_ready}), 64'd1);
        check("hold.kept", 64'(out), 64'h5);

        // Reset while in DONE.
        op = 4'b0100; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rdone.pre", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rdone.ctl", 64'({out_valid, in_ready}), 64'd1);
        check("rdone.out", 64'(out), 64'd0);
        check("rdone.flags", 64'({ofl, z, co, err}), 64'b0100);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rdone", 4'b0100, 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 4'b0000, 1);

`ifdef ALU_SEQ_MUL_EN
        // Reset at cycle 8 of a multiply.
        op = 4'b1001; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("rmul.busy", 64'({out_valid, in_ready}), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rmul.ctl", 64'({out_valid, in_ready}), 64'd1);
        check("rmul.flags", 64'({ofl, z, co, err}), 64'b0100);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rmul", 4'b0100, 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 4'b0000, 1);
        run("mul_after", 4'b1001, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h000F, 4'b0000, 17);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter: SHW, log2(WIDTH), shift-count width; derived, never overridden.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  request present on A/B/op/invB/sign.
REQ-006 Port: in_ready  output  1  block can accept a request this cycle.
REQ-007 Port: A, B  input  WIDTH each  operands.
REQ-008 Port: op  input  4  operation code, see REQ-014.
REQ-009 Port: invB  input  1  AND variant select, B complemented.
REQ-010 Port: sign  input  1  signed-overflow select for ADD/SUB.
REQ-011 Port: out_valid  output  1  result registers hold a valid result.
REQ-012 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-013 Port: out  output  WIDTH (result); ofl, z, co, err  output  1 each (overflow, zero, carry, illegal op); all registered.

Function
REQ-014 Opcodes: 0000 ROL, 0001 SLL, 0010 ROR, 0011 SRL, 0100 ADD A+B, 0101 XOR, 0110 AND (A&~B when invB=1), 0111 SUB A-B, 1000 SUB B-A, 1001 MUL (unsigned, low WIDTH bits); all others are illegal.
REQ-015 Shifts and rotates use count B[SHW-1:0]; higher bits of B are ignored; count 0 passes A unchanged.
REQ-016 SUB is computed as minuend + ~subtrahend + 1 in a single WIDTH-bit adder; co is the adder carry-out.
REQ-017 ofl for ADD/SUB equals signed overflow when sign=1, else co; for MUL, ofl=1 iff the upper WIDTH product bits are nonzero; ofl=0 for all other ops.
REQ-018 co=0 for all ops other than ADD/SUB/MUL; for MUL, co=ofl.
REQ-019 z = (out == 0) for every legal op.
REQ-020 Illegal op: the request completes with the single-cycle latency, err=1, out=0, z=1, ofl=0, co=0.
REQ-021 FSM states: IDLE, MUL, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-022 IDLE & in_valid, non-MUL op: result captured at that edge -> DONE; out_valid rises the next cycle (latency 1).
REQ-023 IDLE & in_valid & op=MUL: operands latched -> MUL; shift-add, one multiplier bit per cycle, for exactly WIDTH cycles -> DONE (latency WIDTH+1).
REQ-024 DONE: out and flags hold stable while out_ready=0; on out_ready=1 -> IDLE, out_valid falls the next cycle.
REQ-025 Inputs are ignored while in_ready=0; a request whose in_valid is deasserted before acceptance is not executed.
REQ-026 Maximum throughput is one result every 2 cycles for single-cycle ops.

Reset
REQ-027 rst_n low at any time, including mid-MUL or in DONE, immediately aborts the operation: state=IDLE, in_ready=1, out_valid=0, out=0, ofl=0, z=1, co=0, err=0; partial product and counter are cleared.
REQ-028 After rst_n rises, the first request is accepted at the first rising edge with in_valid=1.

Configuration
REQ-029 Macro ALU_SEQ_MUL_EN: when defined, MUL state and multiplier datapath are built; when undefined, op 1001 is illegal per REQ-020, the MUL state does not exist, and no multiplier logic is present.

Verification
REQ-030 WIDTH=16, ADD A=7FFF B=0001 sign=1 -> out=8000, ofl=1, co=0, z=0, out_valid 1 cycle after acceptance.
REQ-031 SUB(0111) A=0005 B=0005 -> out=0000, z=1, co=1; SUB(1000) A=0003 B=0001 -> out=FFFE, co=0.
REQ-032 ROR A=8001 B=0011 (count 1) -> out=C000; SLL A=0001 B=000F -> out=8000.
REQ-033 MUL A=0100 B=0100 (macro defined) -> out=0000, ofl=1, co=1, out_valid exactly 17 cycles after acceptance; macro undefined -> err=1 with 1-cycle latency.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE.
REQ-035 rst_n low at cycle 8 of a MUL -> out_valid=0, in_ready=1 immediately; the next ADD 0002+0003 -> out=0005.
